// File: rtl/icache_refill_pkg.sv
// ============================================================================
// Module : icache_refill_pkg
// Brief  : Shared FSM encoding and default geometry for the I-cache refill engine.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package icache_refill_pkg;

    localparam int AW_DEF      = 14;
    localparam int LW_LOG2_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/icache_refill.sv
// ============================================================================
// Module : icache_refill
// Brief  : Critical-word-first line refill with wrap-around inside the line.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int LW_LOG2 = LW_LOG2_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_miss_req,
    input  logic [AW-1:0]      i_miss_addr,
    output logic               o_busy,
    output logic               o_mem_stb,
    output logic [AW-1:0]      o_mem_addr,
    input  logic [31:0]        i_mem_data,
    input  logic               i_mem_ack,
    output logic               o_fill_we,
    output logic [LW_LOG2-1:0] o_fill_word,
    output logic [31:0]        o_fill_data,
    output logic               o_crit_valid,
    output logic [31:0]        o_crit_data,
    output logic               o_done
);

    state_t                  r_state;
    state_t                  w_next;
    logic [AW-LW_LOG2-1:0]   r_base;
    logic [LW_LOG2-1:0]      r_ptr;
    logic [LW_LOG2:0]        r_cnt;
    logic                    r_fill_we;
    logic [LW_LOG2-1:0]      r_fill_word;
    logic [31:0]             r_fill_data;
    logic                    r_crit_valid;
    logic [31:0]             r_crit_data;
    logic                    w_all_acked;
    logic                    w_stb;
    logic                    w_take;

    // The extra count bit marks "every word acked": strobe drops while the
    // last fill write drains, then DONE follows.
    assign w_all_acked = r_cnt[LW_LOG2];
    assign w_stb       = (r_state == ST_FETCH) && !w_all_acked;
    assign w_take      = w_stb && i_mem_ack;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_miss_req) w_next = ST_FETCH;
            ST_FETCH: if (w_all_acked) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_base       <= '0;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_fill_we    <= 1'b0;
            r_fill_word  <= '0;
            r_fill_data  <= '0;
            r_crit_valid <= 1'b0;
            r_crit_data  <= '0;
        end else begin
            r_state      <= w_next;
            r_fill_we    <= w_take;
            r_crit_valid <= w_take && (r_cnt == '0);
            if ((r_state == ST_IDLE) && i_miss_req) begin
                r_base <= i_miss_addr[AW-1:LW_LOG2];
                r_ptr  <= i_miss_addr[LW_LOG2-1:0];
                r_cnt  <= '0;
            end
            if (w_take) begin
                r_fill_word <= r_ptr;
                r_fill_data <= i_mem_data;
                if (r_cnt == '0) r_crit_data <= i_mem_data;
                r_ptr <= r_ptr + 1'b1;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_busy       = (r_state != ST_IDLE);
    assign o_mem_stb    = w_stb;
    assign o_mem_addr   = {r_base, r_ptr};
    assign o_fill_we    = r_fill_we;
    assign o_fill_word  = r_fill_word;
    assign o_fill_data  = r_fill_data;
    assign o_crit_valid = r_crit_valid;
    assign o_crit_data  = r_crit_data;
    assign o_done       = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_icache_refill.sv
// ============================================================================
// Module : tb_icache_refill
// Brief  : Randomized self-checking bench with a word-read memory model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache_refill;

    localparam int AW  = 14;
    localparam int LWL = 2;
    localparam int WPL = 4;
    localparam int RD  = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           miss_req = 1'b0;
    logic [AW-1:0]  miss_addr = '0;
    logic           busy, mem_stb, fill_we, crit_valid, done;
    logic [AW-1:0]  mem_addr;
    logic [LWL-1:0] fill_word;
    logic [31:0]    fill_data, crit_data;
    logic           m_ack = 1'b0, inj_ack = 1'b0;
    logic [31:0]    m_data = '0;
    logic           mem_ack;
    assign mem_ack = m_ack | inj_ack;

    icache_refill #(.AW(AW), .LW_LOG2(LWL)) dut (
        .clk(clk), .rst_n(rst_n), .i_miss_req(miss_req), .i_miss_addr(miss_addr),
        .o_busy(busy), .o_mem_stb(mem_stb), .o_mem_addr(mem_addr),
        .i_mem_data(m_data), .i_mem_ack(mem_ack), .o_fill_we(fill_we),
        .o_fill_word(fill_word), .o_fill_data(fill_data), .o_crit_valid(crit_valid),
        .o_crit_data(crit_data), .o_done(done)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] fake(input logic [AW-1:0] a);
        return 32'hC0F00FCF ^ ({18'd0, a} * 32'h9E3779B1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Memory responder: idle until it sees stb, acks RD-1 cycles later, idles again.
    logic          m_busy = 1'b0;
    int            m_n = 0;
    logic [AW-1:0] m_addr = '0;
    int            addr_unstable = 0;
    initial forever begin
        @(posedge clk); #1;
        if (!rst_n) begin
            m_ack = 1'b0; m_busy = 1'b0; m_n = 0;
        end else begin
            if (m_ack) begin m_ack = 1'b0; m_data = $urandom; end
            if (!m_busy && mem_stb) begin
                m_busy = 1'b1; m_n = 0; m_addr = mem_addr;
            end else if (m_busy) m_n++;
            if (m_busy && !mem_stb) addr_unstable++;
            if (m_busy && mem_stb && mem_addr != m_addr) addr_unstable++;
            if (m_busy && m_n == RD - 1) begin
                m_ack = 1'b1; m_data = fake(m_addr); m_busy = 1'b0;
            end
        end
    end

    // Observation queues sampled on the falling edge.
    int             rise_q[$], fill_cyc_q[$], crit_cyc_q[$], done_q[$];
    logic [LWL-1:0] fill_word_q[$];
    logic [31:0]    fill_data_q[$], crit_q[$];
    logic [AW-1:0]  ack_addr_q[$];
    int             strobe_viol = 0;
    logic           p_stb = 1'b0, p_ack = 1'b0;
    logic [AW-1:0]  p_addr = '0;

    always @(negedge clk) begin
        if (mem_stb && !p_stb) rise_q.push_back(cyc);
        if (fill_we) begin
            fill_cyc_q.push_back(cyc); fill_word_q.push_back(fill_word); fill_data_q.push_back(fill_data);
        end
        if (crit_valid) begin crit_q.push_back(crit_data); crit_cyc_q.push_back(cyc); end
        if (done) done_q.push_back(cyc);
        if (done && mem_stb) strobe_viol++;
        if (p_ack && p_stb && mem_stb && mem_addr == p_addr) strobe_viol++;
        if (mem_ack && mem_stb) ack_addr_q.push_back(mem_addr);
        p_stb = mem_stb; p_ack = mem_ack; p_addr = mem_addr;
    end

    task automatic clr();
        rise_q.delete(); fill_cyc_q.delete(); crit_cyc_q.delete(); done_q.delete();
        fill_word_q.delete(); fill_data_q.delete(); crit_q.delete(); ack_addr_q.delete();
        strobe_viol = 0; addr_unstable = 0;
    endtask

    task automatic start_miss(input logic [AW-1:0] a);
        @(negedge clk); miss_addr = a; miss_req = 1'b1;
        @(negedge clk); miss_req = 1'b0;
    endtask

    // Waits for n done pulses; optional noise on miss_req/miss_addr mid-fetch.
    task automatic wait_done(input int n, input bit noise);
        int k = 0;
        while (done_q.size() < n && k < 400) begin
            @(negedge clk); #1; k++;
            if (noise && rise_q.size() > 0 && cyc - rise_q[rise_q.size()-1] >= 2
                && cyc - rise_q[rise_q.size()-1] <= 36) begin
                miss_req  = 1'($urandom_range(0, 1));
                miss_addr = AW'($urandom);
            end else if (noise) miss_req = 1'b0;
        end
        miss_req = 1'b0;
        if (done_q.size() < n) chk("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_line(input logic [AW-1:0] a, input int off, input string t);
        logic [AW-1:0] base, ea;
        int rise = 0, wi, j;
        base = {a[AW-1:LWL], 2'b00};
        if (rise_q.size() > off) rise = rise_q[off];
        else chk({t, ":rise"}, 0, 1);
        for (int i = 0; i < WPL; i++) begin
            wi = (int'(a % WPL) + i) % WPL;
            ea = base + AW'(wi);
            j  = off * WPL + i;
            if (j < fill_word_q.size()) begin
                chk({t, ":fill_word"}, fill_word_q[j], wi);
                chk({t, ":fill_data"}, fill_data_q[j], fake(ea));
                chk({t, ":fill_cyc"}, fill_cyc_q[j] - rise, RD * (i + 1));
            end else chk({t, ":fill_missing"}, j, fill_word_q.size());
            if (j < ack_addr_q.size()) chk({t, ":mem_addr"}, ack_addr_q[j], ea);
            else chk({t, ":ack_missing"}, j, ack_addr_q.size());
        end
        if (crit_q.size() > off) begin
            chk({t, ":crit_data"}, crit_q[off], fake(a));
            chk({t, ":crit_cyc"}, crit_cyc_q[off] - rise, RD);
        end else chk({t, ":crit_missing"}, crit_q.size(), off + 1);
        if (done_q.size() > off) chk({t, ":done_cyc"}, done_q[off] - rise, 4 * RD + 1);
        else chk({t, ":done_missing"}, done_q.size(), off + 1);
        chk({t, ":strobe_rule"}, strobe_viol, 0);
        chk({t, ":addr_stable"}, addr_unstable, 0);
    endtask

    task automatic stray_ack();
        int n0 = fill_word_q.size();
        @(posedge clk); #1; inj_ack = 1'b1;
        @(posedge clk); #1; inj_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_ack_fill", fill_word_q.size(), n0);
        chk("stray_ack_busy", busy, 0);
    endtask

    initial begin
        logic [AW-1:0] a;
        int g;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy, mem_stb, mem_addr, fill_we, fill_word, crit_valid, done}, 0);
        chk("rst_data", {fill_data, crit_data}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed lines
        clr(); start_miss(14'h0002); wait_done(1, 0);
        check_line(14'h0002, 0, "t1");
        if (fill_data_q.size() > 2) chk("t1:word0_const", fill_data_q[2], 32'hC0F00FCF);
        else chk("t1:word0_missing", fill_data_q.size(), 3);

        clr(); start_miss(14'h0123); wait_done(1, 0);
        check_line(14'h0123, 0, "t2");
        chk("t2:nfill", fill_word_q.size(), 4);

        clr(); start_miss(14'h3FFC); wait_done(1, 0);
        check_line(14'h3FFC, 0, "t3");

        // Held miss_req: second line starts right after DONE; addr changed mid-fetch
        clr();
        @(negedge clk); miss_addr = 14'h2A5; miss_req = 1'b1;
        g = 0;
        while (rise_q.size() < 1 && g < 50) begin @(negedge clk); #1; g++; end
        miss_addr = 14'h0010;
        g = 0;
        while (rise_q.size() < 2 && g < 200) begin @(negedge clk); #1; g++; end
        miss_req = 1'b0;
        wait_done(2, 0);
        check_line(14'h2A5, 0, "t4a");
        check_line(14'h0010, 1, "t4b");
        chk("t4:nfill", fill_word_q.size(), 8);
        if (rise_q.size() > 1 && done_q.size() > 0) chk("t4:restart", rise_q[1] - done_q[0], 2);
        else chk("t4:restart_missing", rise_q.size(), 2);

        // Reset in the middle of a refill
        clr(); start_miss(14'h0155);
        g = 0;
        while (rise_q.size() < 1 && g < 50) begin @(negedge clk); #1; g++; end
        g = 0;
        while (rise_q.size() > 0 && cyc < rise_q[0] + 15 && g < 100) begin @(negedge clk); g++; end
        rst_n = 1'b0;
        @(negedge clk); #1;
        chk("t5:stb_after_rst", mem_stb, 0);
        chk("t5:busy_after_rst", busy, 0);
        chk("t5:fill_we_after_rst", fill_we, 0);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("t5:no_done", done_q.size(), 0);
        chk("t5:partial_fill", fill_word_q.size(), 1);
        clr(); start_miss(14'h0156); wait_done(1, 0);
        check_line(14'h0156, 0, "t5b");

        // Randomized lines with miss_req/miss_addr noise and stray acks
        for (int r = 0; r < 8; r++) begin
            a = AW'($urandom_range(0, (1 << AW) - 1));
            clr(); start_miss(a); wait_done(1, 1);
            check_line(a, 0, $sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d:nfill", r), fill_word_q.size(), 4);
            stray_ack();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
